// File: rtl/joystick_scan_ctrl.sv
// Sequencer for a 74HC165-style joystick shift-register chain.
// Drives the active-low parallel-load strobe and a divided shift clock,
// captures NUM_BITS serial bits per scan and publishes a frame only
// when two consecutive scans agree.
module joystick_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int NUM_BITS = 16,
  parameter int SCAN_GAP = 1024
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                joy_data_i,
  output logic                joy_clk_o,
  output logic                joy_load_o,
  output logic [NUM_BITS-1:0] frame_o,
  output logic                frame_valid_o,
  output logic                busy_o
);

  // Counter widths sized so no counter can wrap inside a scan or a gap.
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(NUM_BITS);
  localparam int GAP_W = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;

  // Divider value on the last cycle of a LOAD or bit period.
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(2 * CLK_DIV - 1);
  // Divider value on the last cycle of the low phase (data sample point).
  localparam logic [DIV_W-1:0] DIV_LOW_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(NUM_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_INIT     = GAP_W'(SCAN_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [GAP_W-1:0]    gap_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [NUM_BITS-1:0] prev_q;
  logic [NUM_BITS-1:0] frame_q;
  logic                valid_q;
  logic                joy_clk_q;
  logic                joy_load_q;
  logic                busy_q;

  // Scan FSM: all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      prev_q     <= '1;
      frame_q    <= '1;
      valid_q    <= 1'b0;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          joy_clk_q  <= 1'b0;
          joy_load_q <= 1'b1;
          if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
          end else if (enable_i) begin
            state_q    <= LOAD;
            joy_load_q <= 1'b0;
            busy_q     <= 1'b1;
            div_q      <= '0;
          end
        end

        LOAD: begin
          if (div_q == DIV_LAST) begin
            state_q    <= SHIFT;
            joy_load_q <= 1'b1;
            div_q      <= '0;
            bit_q      <= '0;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        SHIFT: begin
          // Sample one cycle before the chain sees its rising edge.
          if (div_q == DIV_LOW_LAST) begin
            shift_q <= {shift_q[NUM_BITS-2:0], joy_data_i};
          end
          if (div_q == DIV_LAST) begin
            div_q     <= '0;
            joy_clk_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
              state_q <= DONE;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            div_q     <= div_q + DIV_W'(1);
            // High phase covers divider values CLK_DIV .. 2*CLK_DIV-1.
            joy_clk_q <= (div_q >= DIV_LOW_LAST);
          end
        end

        DONE: begin
          // Two-frame agreement: publish only when this scan matches the last.
          if (shift_q == prev_q) begin
            frame_q <= shift_q;
            valid_q <= 1'b1;
          end
          prev_q  <= shift_q;
          gap_q   <= GAP_INIT;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign joy_clk_o     = joy_clk_q;
  assign joy_load_o    = joy_load_q;
  assign frame_o       = frame_q;
  assign frame_valid_o = valid_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_joystick_scan_ctrl.sv
// Directed bench for joystick_scan_ctrl with a behavioural 74HC165 chain.
module tb_joystick_scan_ctrl;

  logic        clk_i    = 1'b0;
  logic        clk_run  = 1'b0;
  logic        reset_i  = 1'b0;
  logic        enable_i = 1'b0;
  logic        joy_data_i;
  logic        joy_clk_o;
  logic        joy_load_o;
  logic [15:0] frame_o;
  logic        frame_valid_o;
  logic        busy_o;

  int errors    = 0;
  int checks    = 0;
  int valid_cnt = 0;

  logic [15:0] pattern = 16'hFFFF;
  logic [15:0] chain   = 16'hFFFF;

  joystick_scan_ctrl #(
    .CLK_DIV  (2),
    .NUM_BITS (16),
    .SCAN_GAP (10)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .joy_data_i    (joy_data_i),
    .joy_clk_o     (joy_clk_o),
    .joy_load_o    (joy_load_o),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .busy_o        (busy_o)
  );

  always #5 if (clk_run) clk_i = ~clk_i;

  // Chain model: parallel load on falling load strobe, shift on rising clock.
  always @(negedge joy_load_o) chain <= pattern;
  always @(posedge joy_clk_o)  chain <= {chain[14:0], 1'b1};
  assign joy_data_i = chain[15];

  // Counts strobe cycles; sampled at the edge that ends each cycle.
  always @(posedge clk_i) if (frame_valid_o) valid_cnt <= valid_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a scan (counting idle samples), then profiles it until busy drops.
  // Called and returning on a negedge; the final sample is the first idle cycle.
  task automatic run_scan(input int drop_at, output int idle_n, output int busy_n,
                          output int load_n, output int hi_n, output int rise_n,
                          output int first_rise, output logic valid_end,
                          output logic [15:0] frame_end);
    logic prev_clk;
    idle_n = 0; busy_n = 0; load_n = 0; hi_n = 0; rise_n = 0; first_rise = -1;
    valid_end = 1'b0; frame_end = 16'h0; prev_clk = 1'b0;
    while (!busy_o) begin
      if (idle_n >= 300) begin
        check("scan_start_timeout", 32'(idle_n), 32'd0);
        return;
      end
      idle_n++;
      @(negedge clk_i);
    end
    while (busy_o) begin
      if (busy_n >= 300) begin
        check("scan_end_timeout", 32'(busy_n), 32'd69);
        return;
      end
      if (busy_n == drop_at) enable_i = 1'b0;
      if (!joy_load_o) load_n++;
      if (joy_clk_o) hi_n++;
      if (joy_clk_o && !prev_clk) begin
        rise_n++;
        if (first_rise < 0) first_rise = busy_n;
      end
      prev_clk = joy_clk_o;
      busy_n++;
      @(negedge clk_i);
    end
    valid_end = frame_valid_o;
    frame_end = frame_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_n, busy_n, load_n, hi_n, rise_n, first_rise, n, loads_seen;
    logic valid_end;
    logic [15:0] frame_end;

    // Reset applied before any clock edge.
    #1 reset_i = 1'b1;
    #1;
    check("rst_load",  32'(joy_load_o), 32'd1);
    check("rst_clk",   32'(joy_clk_o), 32'd0);
    check("rst_frame", 32'(frame_o), 32'hFFFF);
    check("rst_valid", 32'(frame_valid_o), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);

    clk_run  = 1'b1;
    enable_i = 1'b1;
    pattern  = 16'hA5C3;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    // Scan 1: timing profile; differs from reset raw frame, so no strobe.
    run_scan(-1, idle_n, busy_n, load_n, hi_n, rise_n, first_rise, valid_end, frame_end);
    check("s1_idle",       32'(idle_n), 32'd1);
    check("s1_load_cyc",   32'(load_n), 32'd4);
    check("s1_clk_hi_cyc", 32'(hi_n), 32'd32);
    check("s1_rises",      32'(rise_n), 32'd16);
    check("s1_first_rise", 32'(first_rise), 32'd6);
    check("s1_busy_cyc",   32'(busy_n), 32'd69);
    check("s1_valid",      32'(valid_end), 32'd0);
    check("s1_frame",      32'(frame_end), 32'hFFFF);

    // Scan 2: same data agrees, strobe with A5C3.
    run_scan(-1, idle_n, busy_n, load_n, hi_n, rise_n, first_rise, valid_end, frame_end);
    check("s2_gap",   32'(idle_n), 32'd11);
    check("s2_busy",  32'(busy_n), 32'd69);
    check("s2_valid", 32'(valid_end), 32'd1);
    check("s2_frame", 32'(frame_end), 32'hA5C3);

    // Scan 3: enable dropped mid-SHIFT; scan still completes.
    pattern = 16'h1234;
    run_scan(30, idle_n, busy_n, load_n, hi_n, rise_n, first_rise, valid_end, frame_end);
    check("s3_rises",     32'(rise_n), 32'd16);
    check("s3_busy",      32'(busy_n), 32'd69);
    check("s3_valid",     32'(valid_end), 32'd0);
    check("s3_frame",     32'(frame_end), 32'hA5C3);
    check("s3_valid_cnt", 32'(valid_cnt), 32'd1);

    // Enable held low well past the gap: no further load strobe.
    loads_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (!joy_load_o || busy_o) loads_seen++;
      @(negedge clk_i);
    end
    check("dis_no_load", 32'(loads_seen), 32'd0);

    // Re-enable after the gap expired: LOAD on the next edge.
    enable_i = 1'b1;
    run_scan(-1, idle_n, busy_n, load_n, hi_n, rise_n, first_rise, valid_end, frame_end);
    check("s4_idle",  32'(idle_n), 32'd1);
    check("s4_valid", 32'(valid_end), 32'd1);
    check("s4_frame", 32'(frame_end), 32'h1234);

    // Next scan: reset in the high phase of bit 7.
    n = 0;
    while (!busy_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check("r_scan_started", 32'(busy_o), 32'd1);
    check("r_valid_cnt",    32'(valid_cnt), 32'd2);
    repeat (34) @(negedge clk_i);
    check("r_bit7_clk_hi", 32'(joy_clk_o), 32'd1);
    reset_i  = 1'b1;
    enable_i = 1'b0;
    #1;
    check("r_clk",   32'(joy_clk_o), 32'd0);
    check("r_load",  32'(joy_load_o), 32'd1);
    check("r_busy",  32'(busy_o), 32'd0);
    check("r_frame", 32'(frame_o), 32'hFFFF);
    check("r_valid", 32'(frame_valid_o), 32'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("r_idle_busy",   32'(busy_o), 32'd0);
    check("r_no_strobe",   32'(valid_cnt), 32'd2);

    // Debounce after reset: FFFE, FFFD, FFFD.
    pattern  = 16'hFFFE;
    enable_i = 1'b1;
    run_scan(-1, idle_n, busy_n, load_n, hi_n, rise_n, first_rise, valid_end, frame_end);
    check("da_idle",  32'(idle_n), 32'd1);
    check("da_valid", 32'(valid_end), 32'd0);
    check("da_frame", 32'(frame_end), 32'hFFFF);

    pattern = 16'hFFFD;
    run_scan(-1, idle_n, busy_n, load_n, hi_n, rise_n, first_rise, valid_end, frame_end);
    check("db_valid", 32'(valid_end), 32'd0);
    check("db_frame", 32'(frame_end), 32'hFFFF);

    run_scan(-1, idle_n, busy_n, load_n, hi_n, rise_n, first_rise, valid_end, frame_end);
    check("dc_valid", 32'(valid_end), 32'd1);
    check("dc_frame", 32'(frame_end), 32'hFFFD);
    repeat (3) @(negedge clk_i);
    check("dc_valid_cnt", 32'(valid_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
